// File: rtl/Common.sv
// Shared enumerations for the neural-network datapath blocks.
package Common;

   typedef enum logic [1:0] {
      Sigmoid,
      ReLU,
      Linear
   } act_func;

endpackage

// File: rtl/FixedPoint.sv
// Signed Q32.32 fixed-point type and saturating arithmetic helpers.
package FixedPoint;

   typedef logic signed [63:0] sfp;

   localparam sfp ONE     = 64'sh0000_0001_0000_0000;
   localparam sfp HALF    = 64'sh0000_0000_8000_0000;
   localparam sfp EPSILON = 64'sh0000_0000_0000_0001;
   localparam sfp SFP_MAX = 64'sh7FFF_FFFF_FFFF_FFFF;
   localparam sfp SFP_MIN = 64'sh8000_0000_0000_0000;

   // A 128-bit value fits in sfp only when its top 65 bits agree.
   function automatic sfp sat128(input logic [127:0] v);
      if (&v[127:63] || ~|v[127:63]) return v[63:0];
      return v[127] ? SFP_MIN : SFP_MAX;
   endfunction

   function automatic sfp sfp_add(input sfp a, input sfp b);
      logic [64:0] s;
      s = {a[63], a} + {b[63], b};
      if (s[64] != s[63]) return s[64] ? SFP_MIN : SFP_MAX;
      return s[63:0];
   endfunction

   function automatic sfp sfp_sub(input sfp a, input sfp b);
      logic [64:0] s;
      s = {a[63], a} - {b[63], b};
      if (s[64] != s[63]) return s[64] ? SFP_MIN : SFP_MAX;
      return s[63:0];
   endfunction

   function automatic sfp sfp_mul(input sfp a, input sfp b);
      logic signed [127:0] p;
      p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
      return sat128(p >>> 32);
   endfunction

   function automatic sfp sfp_div(input sfp a, input sfp b);
      logic signed [127:0] n;
      logic signed [127:0] d;
      if (b == '0) return a[63] ? SFP_MIN : SFP_MAX;
      n = $signed({{32{a[63]}}, a, 32'b0});
      d = $signed({{64{b[63]}}, b});
      return sat128(n / d);
   endfunction

endpackage

// File: rtl/activation_unit.sv
// Activation function and its derivative; sigmoid uses the shift/add PLAN approximation.
module activation_unit
   import Common::*;
   import FixedPoint::*;
(
   input  logic signed [63:0] z,
   input  act_func            activation,
   output logic signed [63:0] act,
   output logic signed [63:0] act_deriv
);

   localparam sfp SIG_SAT  = 64'sh0000_0005_0000_0000;  // 5.0
   localparam sfp SIG_BRK2 = 64'sh0000_0002_6000_0000;  // 2.375
   localparam sfp SIG_OFF2 = 64'sh0000_0000_D800_0000;  // 0.84375
   localparam sfp SIG_OFF1 = 64'sh0000_0000_A000_0000;  // 0.625

   sfp mag;
   sfp f;
   sfp sig;

   always_comb begin
      mag = z[63] ? sfp_sub('0, z) : z;
      if (mag >= SIG_SAT)       f = ONE;
      else if (mag >= SIG_BRK2) f = (mag >>> 5) + SIG_OFF2;
      else if (mag >= ONE)      f = (mag >>> 3) + SIG_OFF1;
      else                      f = (mag >>> 2) + HALF;
      // f lies in [0.5, 1], so the mirror for negative z cannot overflow
      sig = z[63] ? ONE - f : f;

      act       = z;
      act_deriv = ONE;
      case (activation)
         Sigmoid: begin
            act       = sig;
            act_deriv = sfp_mul(sig, ONE - sig);
         end
         ReLU: begin
            act       = (z > 0) ? z : '0;
            act_deriv = (z > 0) ? ONE : '0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/perceptron.sv
// Single trainable neuron: combinational forward/backward path, registered weights and bias.
module perceptron
   import Common::*;
   import FixedPoint::*;
#(
   parameter int unsigned input_units  = 2,
   parameter int unsigned output_units = 1
)(
   input  logic               clk,
   input  logic               rst,
   input  logic signed [63:0] values [input_units],
   input  act_func            activation,
   input  logic               training,
   input  logic signed [63:0] learning_rate,
   input  logic signed [63:0] next_layer_weights [output_units],
   input  logic signed [63:0] error_gradient_next_layer [output_units],
   output logic signed [63:0] prediction,
   output logic signed [63:0] error_gradient,
   output logic signed [63:0] current_weights [input_units]
);

   localparam sfp W_EVEN = ONE >>> 3;
   localparam sfp W_ODD  = -(ONE >>> 4);

   sfp w    [input_units];
   sfp prod [input_units];
   sfp back [output_units];
   sfp bias;
   sfp z_sum;
   sfp back_sum;
   sfp act_deriv;

   for (genvar i = 0; i < input_units; i++) begin : g_mac
      assign prod[i] = sfp_mul(w[i], values[i]);
   end

   for (genvar k = 0; k < output_units; k++) begin : g_back
      assign back[k] = sfp_mul(next_layer_weights[k], error_gradient_next_layer[k]);
   end

   // Saturating accumulation in fixed order: bias first, then input 0 upward.
   always_comb begin
      z_sum = bias;
      for (int unsigned i = 0; i < input_units; i++)
         z_sum = sfp_add(z_sum, prod[i]);
      back_sum = '0;
      for (int unsigned k = 0; k < output_units; k++)
         back_sum = sfp_add(back_sum, back[k]);
   end

   activation_unit u_act (
      .z          (z_sum),
      .activation (activation),
      .act        (prediction),
      .act_deriv  (act_deriv)
   );

   assign error_gradient = sfp_mul(back_sum, act_deriv);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < input_units; i++)
            w[i] <= i[0] ? W_ODD : W_EVEN;
         bias <= '0;
      end else if (training) begin
         for (int unsigned i = 0; i < input_units; i++)
            w[i] <= sfp_sub(w[i], sfp_mul(learning_rate, sfp_mul(error_gradient, values[i])));
         bias <= sfp_sub(bias, sfp_mul(learning_rate, error_gradient));
      end
   end

   assign current_weights = w;

endmodule

// File: tb/tb_perceptron.sv
// Bench for perceptron: directed vector table, training sequences and a randomized model comparison.
module tb_perceptron;
   import Common::*;

   typedef logic signed [63:0] fx_t;

   localparam fx_t ONE  = 64'sh0000_0001_0000_0000;
   localparam fx_t HALF = 64'sh0000_0000_8000_0000;
   localparam fx_t EPS  = 64'sh0000_0000_0000_0001;
   localparam fx_t LMAX = 64'sh7FFF_FFFF_FFFF_FFFF;
   localparam fx_t LMIN = 64'sh8000_0000_0000_0000;
   localparam fx_t RW0  = 64'sh0000_0000_2000_0000;
   localparam fx_t RW1  = -64'sh0000_0000_1000_0000;

   typedef struct {
      act_func act;
      fx_t v0, v1, nw0, nw1, g0, g1;
      fx_t pred, grad;
   } vec_t;

   logic    clk = 1'b0;
   logic    rst;
   logic    training;
   act_func act_sel;
   fx_t     lr;
   fx_t     values [2];
   fx_t     nlw [2];
   fx_t     ngr [2];
   fx_t     cur_w [2];
   fx_t     prediction;
   fx_t     error_gradient;

   int  vectors = 0;
   int  miscompares = 0;
   fx_t mw [2];
   fx_t mb;
   vec_t tbl [12];

   always #5 clk = ~clk;

   perceptron #(.input_units(2), .output_units(2)) dut (
      .clk                       (clk),
      .rst                       (rst),
      .values                    (values),
      .activation                (act_sel),
      .training                  (training),
      .learning_rate             (lr),
      .next_layer_weights        (nlw),
      .error_gradient_next_layer (ngr),
      .prediction                (prediction),
      .error_gradient            (error_gradient),
      .current_weights           (cur_w)
   );

   task automatic check(input string name, input fx_t got, input fx_t exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference arithmetic: exact 128-bit math clamped to the Q32.32 range.
   function automatic fx_t m_sat(input logic signed [127:0] v);
      if (v > LMAX) return LMAX;
      if (v < LMIN) return LMIN;
      return v[63:0];
   endfunction

   function automatic fx_t m_add(input fx_t a, input fx_t b);
      logic signed [127:0] wa, wb;
      wa = a; wb = b;
      return m_sat(wa + wb);
   endfunction

   function automatic fx_t m_sub(input fx_t a, input fx_t b);
      logic signed [127:0] wa, wb;
      wa = a; wb = b;
      return m_sat(wa - wb);
   endfunction

   function automatic fx_t m_mul(input fx_t a, input fx_t b);
      logic signed [127:0] wa, wb;
      wa = a; wb = b;
      return m_sat((wa * wb) >>> 32);
   endfunction

   function automatic fx_t m_div(input fx_t a, input fx_t b);
      logic signed [127:0] wa, wb;
      if (b == 0) return (a < 0) ? LMIN : LMAX;
      wa = a; wb = b;
      return m_sat((wa * 128'sd4294967296) / wb);
   endfunction

   function automatic void model_eval(output fx_t p, output fx_t dlt);
      fx_t z, a, f, d, s;
      z = mb;
      for (int i = 0; i < 2; i++) z = m_add(z, m_mul(mw[i], values[i]));
      a = (z < 0) ? m_sub(0, z) : z;
      if (a >= ONE * 5)           f = ONE;
      else if (a >= ONE * 19 / 8) f = a / 32 + ONE * 27 / 32;
      else if (a >= ONE)          f = a / 8 + ONE * 5 / 8;
      else                        f = a / 4 + ONE / 2;
      case (act_sel)
         Sigmoid: begin p = (z < 0) ? ONE - f : f; d = m_mul(p, ONE - p); end
         ReLU:    begin p = (z > 0) ? z : 0;       d = (z > 0) ? ONE : 0;  end
         default: begin p = z;                     d = ONE;                end
      endcase
      s = m_add(m_mul(nlw[0], ngr[0]), m_mul(nlw[1], ngr[1]));
      dlt = m_mul(s, d);
   endfunction

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_edge();
      fx_t p, dlt;
      model_eval(p, dlt);
      if (rst) begin
         mw[0] = ONE / 8; mw[1] = -ONE / 16; mb = 0;
      end else if (training) begin
         for (int i = 0; i < 2; i++) mw[i] = m_sub(mw[i], m_mul(lr, m_mul(dlt, values[i])));
         mb = m_sub(mb, m_mul(lr, dlt));
      end
   endtask

   function automatic fx_t rnd(input int sh);
      fx_t r;
      r = fx_t'({32'b0, $urandom}) - HALF;
      return r <<< sh;
   endfunction

   function automatic fx_t bce(input fx_t p, input bit y);
      if (y) return m_sub(0, m_div(ONE, m_add(p, EPS)));
      return m_div(ONE, m_sub(m_sub(ONE, p), EPS));
   endfunction

   initial begin
      fx_t p, dlt;
      bit  y;
      int  correct;

      tbl[0]  = '{Sigmoid, 0, 0, ONE, 0, ONE, 0, HALF, 64'sh4000_0000};
      tbl[1]  = '{Linear, ONE, 0, 64'sh2_0000_0000, 0, 64'sh3_0000_0000, 0, RW0, 64'sh6_0000_0000};
      tbl[2]  = '{ReLU, 0, ONE, ONE, 0, ONE, 0, 0, 0};
      tbl[3]  = '{ReLU, ONE, 0, ONE, 0, ONE, 0, RW0, ONE};
      tbl[4]  = '{Sigmoid, 64'sh28_0000_0000, 0, ONE, 0, ONE, 0, ONE, 0};
      tbl[5]  = '{Sigmoid, 0, 64'sh50_0000_0000, ONE, 0, ONE, 0, 0, 0};
      tbl[6]  = '{Sigmoid, 64'sh8_0000_0000, 0, ONE, 0, ONE, 0, 64'shC000_0000, 64'sh3000_0000};
      tbl[7]  = '{Sigmoid, 64'sh13_0000_0000, 0, ONE, 0, ONE, 0, 64'shEB00_0000, 64'sh1347_0000};
      tbl[8]  = '{Linear, 0, 0, LMAX, 0, 64'sh2_0000_0000, 0, 0, LMAX};
      tbl[9]  = '{Sigmoid, 0, 0, ONE, 64'sh2_0000_0000, ONE, ONE, HALF, 64'shC000_0000};
      tbl[10] = '{Linear, 0, 0, LMAX, 0, -64'sh2_0000_0000, 0, 0, LMIN};
      tbl[11] = '{Sigmoid, 0, 64'sh10_0000_0000, ONE, 0, ONE, 0, 64'sh4000_0000, 64'sh3000_0000};

      rst = 1'b1; training = 1'b0; act_sel = Sigmoid; lr = 0;
      for (int i = 0; i < 2; i++) begin values[i] = 0; nlw[i] = 0; ngr[i] = 0; end
      repeat (3) begin model_edge(); tick(); end
      check("rst_w0", cur_w[0], RW0);
      check("rst_w1", cur_w[1], RW1);
      check("rst_pred", prediction, HALF);
      rst = 1'b0;

      for (int n = 0; n < 12; n++) begin
         act_sel = tbl[n].act;
         values[0] = tbl[n].v0; values[1] = tbl[n].v1;
         nlw[0] = tbl[n].nw0;   nlw[1] = tbl[n].nw1;
         ngr[0] = tbl[n].g0;    ngr[1] = tbl[n].g1;
         #2;
         check($sformatf("vec%0d_pred", n), prediction, tbl[n].pred);
         check($sformatf("vec%0d_grad", n), error_gradient, tbl[n].grad);
      end
      check("idle_w0", cur_w[0], RW0);
      check("idle_w1", cur_w[1], RW1);

      tick();
      act_sel = Sigmoid; values[0] = ONE; values[1] = ONE;
      nlw[0] = ONE; nlw[1] = 0; ngr[0] = ONE; ngr[1] = 0; lr = ONE; training = 1'b1;
      #1;
      check("step_pred", prediction, 64'sh8400_0000);
      check("step_grad", error_gradient, 64'sh3FF0_0000);
      tick();
      training = 1'b0;
      check("step_w0", cur_w[0], -64'sh1FF0_0000);
      check("step_w1", cur_w[1], -64'sh4FF0_0000);

      repeat (5) begin
         ngr[0] = rnd(2); ngr[1] = rnd(2); lr = rnd(1);
         tick();
      end
      check("hold_w0", cur_w[0], -64'sh1FF0_0000);
      check("hold_w1", cur_w[1], -64'sh4FF0_0000);

      training = 1'b1; lr = ONE / 4; nlw[0] = ONE; ngr[0] = ONE;
      repeat (3) begin values[0] = rnd(2); values[1] = rnd(2); tick(); end
      rst = 1'b1;
      model_edge();
      tick();
      check("midrst_w0", cur_w[0], RW0);
      check("midrst_w1", cur_w[1], RW1);
      rst = 1'b0;

      act_sel = Sigmoid; lr = ONE; nlw[0] = ONE; nlw[1] = 0; ngr[1] = 0; training = 1'b1;
      for (int ep = 0; ep < 10; ep++) begin
         for (int s = 0; s < 4; s++) begin
            values[0] = ((s >> 1) & 1) != 0 ? ONE : 0;
            values[1] = (s & 1) != 0 ? ONE : 0;
            y = (s == 3);
            model_eval(p, dlt);
            ngr[0] = bce(p, y);
            #1;
            check($sformatf("and_e%0d_s%0d_pred", ep, s), prediction, p);
            model_edge();
            tick();
         end
      end
      training = 1'b0;
      correct = 0;
      for (int s = 0; s < 4; s++) begin
         values[0] = ((s >> 1) & 1) != 0 ? ONE : 0;
         values[1] = (s & 1) != 0 ? ONE : 0;
         #1;
         if ((prediction >= HALF) == (s == 3)) correct++;
      end
      check("and_correct", fx_t'(correct), 4);
      check("and_w0", cur_w[0], mw[0]);
      check("and_w1", cur_w[1], mw[1]);

      tick();
      for (int n = 0; n < 300; n++) begin
         act_sel = act_func'($urandom_range(0, 2));
         for (int i = 0; i < 2; i++) begin
            values[i] = rnd(3); nlw[i] = rnd(1); ngr[i] = rnd(1);
         end
         lr = fx_t'({32'b0, $urandom_range(0, 32'h4000_0000)});
         training = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 31) == 0);
         #1;
         model_eval(p, dlt);
         check($sformatf("rnd%0d_pred", n), prediction, p);
         check($sformatf("rnd%0d_grad", n), error_gradient, dlt);
         model_edge();
         tick();
         check($sformatf("rnd%0d_w0", n), cur_w[0], mw[0]);
         check($sformatf("rnd%0d_w1", n), cur_w[1], mw[1]);
      end
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
